// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with a shared memory port.
// Optional CPU_SEQ_PERF_EN adds busy-cycle and retire counters.
module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic [3:0]       opcode,
   input  logic             Eq,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_en,
   output logic             rf_we,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             instr_done,
   output logic             busy,
`ifdef CPU_SEQ_PERF_EN
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt,
`endif
   output logic             fault
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [7:0] wait_q, wait_d;
   logic       limit;

   assign busy  = state_q != IDLE && state_q != FAULT;
   assign fault = state_q == FAULT;
   assign limit = wait_q == 8'(MEM_TIMEOUT);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      wait_d     = wait_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_en      = 1'b0;
      rf_we      = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      case (state_q)
         IDLE:   state_d = start ? FETCH : IDLE;
         FETCH: begin
            mem_req = 1'b1;
            ir_en   = mem_ready;
            state_d = mem_ready ? DECODE : limit ? FAULT : FETCH;
            wait_d  = mem_ready ? 8'd0 : wait_q + 8'd1;
         end
         DECODE: begin
            op_d    = opcode;
            state_d = EXEC;
         end
         EXEC: begin
            pc_en      = op_q == 4'h7 || op_q == 4'h8 || op_q == 4'h9;
            instr_done = pc_en;
            // beq takes the branch on Eq, bne on ~Eq
            pc_src     = op_q == 4'h7 ? 2'b01 :
                         (pc_en && ((op_q == 4'h8) == Eq)) ? 2'b10 : 2'b00;
            state_d    = op_q >= 4'hE ? MEM : WB;
         end
         MEM: begin
            mem_req    = 1'b1;
            addr_sel   = 1'b1;
            mem_we     = op_q == 4'hF;
            pc_en      = mem_ready && mem_we;
            instr_done = pc_en;
            state_d    = mem_ready ? WB : limit ? FAULT : MEM;
            wait_d     = mem_ready ? 8'd0 : wait_q + 8'd1;
         end
         WB: begin
            rf_we      = 1'b1;
            pc_en      = 1'b1;
            instr_done = 1'b1;
         end
         default: state_d = FAULT;
      endcase
      if (instr_done) state_d = halt_req ? IDLE : FETCH;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= 4'h0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
      end
   end

`ifdef CPU_SEQ_PERF_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;

   assign cyc_cnt = cyc_cnt_q;
   assign ret_cnt = ret_cnt_q;

   always_comb begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(busy);
      ret_cnt_d = ret_cnt_q + CNT_W'(instr_done);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cyc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction streams checked against a per-instruction timeline model.
module tb_cpu_sequencer;
   localparam int TO = 15;
   localparam int CW = 32;
   logic clk = 0, reset_n = 0, start = 0, halt_req = 0, Eq = 0, mem_ready = 0;
   logic [3:0] opcode = 0;
   logic mem_req, mem_we, addr_sel, ir_en, rf_we, pc_en, instr_done, busy, fault;
   logic [1:0] pc_src;
   logic [10:0] obs;
`ifdef CPU_SEQ_PERF_EN
   logic [CW-1:0] cyc_cnt, ret_cnt;
`endif
   int vecs = 0, errs = 0;
   int m_cyc = 0, m_ret = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req), .opcode(opcode),
      .Eq(Eq), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_en(ir_en), .rf_we(rf_we), .pc_en(pc_en), .pc_src(pc_src), .instr_done(instr_done),
      .busy(busy),
`ifdef CPU_SEQ_PERF_EN
      .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
      .fault(fault));

   assign obs = {mem_req, mem_we, addr_sel, ir_en, rf_we, pc_en, pc_src, instr_done, busy, fault};

   // Instruction length in cycles: fetch (fw+1), decode, exec, optional mem (mw+1), optional write-back.
   function automatic int ilen(input logic [3:0] op, input int fw, input int mw);
      int n;
      n = fw + 3;
      if (op >= 4'hE) n += mw + 1;
      if (op <= 4'h6 || (op >= 4'hA && op <= 4'hE)) n += 1;
      return n;
   endfunction

   // Expected outputs at cycle k of an instruction.
   // Bits: mem_req mem_we addr_sel ir_en rf_we pc_en pc_src[1:0] instr_done busy fault.
   function automatic logic [10:0] model(input logic [3:0] op, input logic eq, input int fw,
                                         input int mw, input int k);
      logic [10:0] v;
      logic taken;
      v = 11'b000_0000_0010;
      taken = (op == 4'h8) ? eq : !eq;
      if (k <= fw) begin
         v[10] = 1'b1;
         v[7] = (k == fw);
      end else if (k == fw + 1) begin
         v = v;
      end else if (k == fw + 2) begin
         if (op == 4'h7) v[5:2] = 4'b1011;
         else if (op == 4'h8 || op == 4'h9) v[5:2] = taken ? 4'b1101 : 4'b1001;
      end else if (op >= 4'hE && k <= fw + 3 + mw) begin
         v[10] = 1'b1;
         v[8] = 1'b1;
         v[9] = (op == 4'hF);
         if (op == 4'hF && k == fw + 3 + mw) v[5:2] = 4'b1001;
      end else begin
         v[6:2] = 5'b11001;
      end
      return v;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      #1;
      vecs++;
      if (obs !== 11'b0) begin
         errs++;
         $display("FAIL reset_state: got %b, want %b", obs, 11'b0);
      end
      reset_n = 1;
      start = 1;
      mem_ready = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      opcode = 4'hE;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 0;
      #1;
      vecs++;
      if (obs !== 11'b101_0000_0010) begin
         errs++;
         $display("FAIL mid_mem: got %b, want %b", obs, 11'b101_0000_0010);
      end
      reset_n = 0;
      @(negedge clk);
      mem_ready = 1;
      #1;
      vecs++;
      if (obs !== 11'b0) begin
         errs++;
         $display("FAIL reset_mid_mem: got %b, want %b", obs, 11'b0);
      end
`ifdef CPU_SEQ_PERF_EN
      vecs++;
      if (cyc_cnt !== 0 || ret_cnt !== 0) begin
         errs++;
         $display("FAIL reset_counters: got %0d/%0d, want 0/0", cyc_cnt, ret_cnt);
      end
`endif
      reset_n = 1;
      mem_ready = 0;
   endtask

   task automatic test_random(input int n_instr);
      logic [3:0] op;
      logic eq, h;
      logic [10:0] exp;
      int fw, mw, len;
      @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      start = 1;
      m_cyc = 0;
      m_ret = 0;
      #1;
      vecs++;
      if (obs !== 11'b0) begin
         errs++;
         $display("FAIL idle_start: got %b, want %b", obs, 11'b0);
      end
      for (int n = 0; n < n_instr; n++) begin
         op = 4'($urandom_range(0, 15));
         eq = 1'($urandom);
         h = ($urandom_range(0, 3) == 0);
         fw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
         mw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
         len = ilen(op, fw, mw);
         for (int k = 0; k < len; k++) begin
            @(negedge clk);
            start = 1'($urandom);
            opcode = (k == fw + 1) ? op : 4'($urandom);
            Eq = (k == fw + 2) ? eq : 1'($urandom);
            if (k <= fw) mem_ready = (k == fw);
            else if (op >= 4'hE && k >= fw + 3 && k <= fw + 3 + mw) mem_ready = (k == fw + 3 + mw);
            else mem_ready = 1'($urandom);
            halt_req = (k == len - 1) ? h : 1'($urandom);
            #1;
            exp = model(op, eq, fw, mw, k);
            vecs++;
            if (obs !== exp) begin
               errs++;
               $display("FAIL seq op=%h fw=%0d mw=%0d k=%0d: got %b, want %b", op, fw, mw, k, obs, exp);
            end
`ifdef CPU_SEQ_PERF_EN
            vecs++;
            if (cyc_cnt !== CW'(m_cyc) || ret_cnt !== CW'(m_ret)) begin
               errs++;
               $display("FAIL counters: got %0d/%0d, want %0d/%0d", cyc_cnt, ret_cnt, m_cyc, m_ret);
            end
`endif
            m_cyc += int'(exp[1]);
            m_ret += int'(exp[2]);
         end
         if (h) begin
            for (int i = 0; i < 2; i++) begin
               @(negedge clk);
               start = (i == 1);
               mem_ready = 1'($urandom);
               halt_req = 1'($urandom);
               #1;
               vecs++;
               if (obs !== 11'b0) begin
                  errs++;
                  $display("FAIL halted_idle: got %b, want %b", obs, 11'b0);
               end
            end
         end
      end
      start = 0;
      halt_req = 1;
      @(negedge clk);
      halt_req = 0;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      start = 1;
      for (int k = 0; k <= TO; k++) begin
         @(negedge clk);
         start = 0;
         mem_ready = 0;
         #1;
         vecs++;
         if (obs !== 11'b100_0000_0010) begin
            errs++;
            $display("FAIL timeout_wait k=%0d: got %b, want %b", k, obs, 11'b100_0000_0010);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1;
         mem_ready = 1'($urandom);
         #1;
         vecs++;
         if (obs !== 11'b1) begin
            errs++;
            $display("FAIL fault_sticky i=%0d: got %b, want %b", i, obs, 11'b1);
         end
      end
`ifdef CPU_SEQ_PERF_EN
      vecs++;
      if (cyc_cnt !== CW'(TO + 1) || ret_cnt !== 0) begin
         errs++;
         $display("FAIL fault_counters: got %0d/%0d, want %0d/0", cyc_cnt, ret_cnt, TO + 1);
      end
`endif
      reset_n = 0;
      start = 0;
      @(negedge clk);
      #1;
      vecs++;
      if (obs !== 11'b0) begin
         errs++;
         $display("FAIL fault_reset: got %b, want %b", obs, 11'b0);
      end
      reset_n = 1;
   endtask

   task automatic test_halt_perf();
      logic [10:0] exp;
      @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      start = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 0;
         mem_ready = 1;
         opcode = 4'h4;
         halt_req = (k == 3);
         #1;
         exp = model(4'h4, 1'b0, 0, 0, k);
         vecs++;
         if (obs !== exp) begin
            errs++;
            $display("FAIL halt_add k=%0d: got %b, want %b", k, obs, exp);
         end
      end
      @(negedge clk);
      halt_req = 0;
      #1;
      vecs++;
      if (obs !== 11'b0) begin
         errs++;
         $display("FAIL halt_idle: got %b, want %b", obs, 11'b0);
      end
`ifdef CPU_SEQ_PERF_EN
      vecs++;
      if (cyc_cnt !== 4 || ret_cnt !== 1) begin
         errs++;
         $display("FAIL halt_counters: got %0d/%0d, want 4/1", cyc_cnt, ret_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_random(80);
      test_timeout();
      test_halt_perf();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
